// File: rtl/stopwatch_display_if.sv
// Stopwatch count/mode inputs and multiplexed seven-segment drive for stopwatch_display.
interface stopwatch_display_if;
  logic [5:0] seconds;
  logic [5:0] minutes;
  logic       adjust;
  logic       select;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  modport master (output seconds, minutes, adjust, select, input an, seg, dp);
  modport slave  (input seconds, minutes, adjust, select, output an, seg, dp);
endinterface

// File: rtl/stopwatch_display.sv
// MM.SS multiplexed 4-digit common-anode display driver with adjust-mode blinking.
// Optional leading-zero blanking of the minutes tens digit: define STOPWATCH_DISPLAY_LZB_EN.
module stopwatch_display #(
  parameter int unsigned CLK_HZ     = 100000000,
  parameter int unsigned REFRESH_HZ = 500,
  parameter int unsigned BLINK_HZ   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  stopwatch_display_if.slave   bus
);

  localparam int unsigned DIGIT_DIV  = CLK_HZ / (REFRESH_HZ * 4);
  localparam int unsigned BLINK_HALF = CLK_HZ / (BLINK_HZ * 2);
  localparam int unsigned DIV_W      = (DIGIT_DIV > 1) ? $clog2(DIGIT_DIV) : 1;
  localparam int unsigned BLK_W      = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int unsigned VAL_W      = 6;
  localparam int unsigned CAP_W      = 2 * VAL_W;

  typedef enum logic {PH_VISIBLE = 1'b0, PH_HIDDEN = 1'b1} phase_t;

  logic [CAP_W-1:0] s1, s2, cap;
  logic [DIV_W-1:0] digit_cnt;
  logic [1:0]       digit_idx;
  logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
  phase_t           phase_q, phase_d;
  logic             adjust_q;
  logic             rise_c;
  logic [VAL_W-1:0] cap_min, cap_sec;
  logic [3:0]       digit_c;
  logic             blank_c;
  logic             lzb_c;
  logic [3:0]       an_c;
  logic [6:0]       seg_c;
  logic             dp_c;

  function automatic logic [6:0] seg_lut(input logic [3:0] d);
    case (d)
      4'd0:    seg_lut = 7'b1000000;
      4'd1:    seg_lut = 7'b1111001;
      4'd2:    seg_lut = 7'b0100100;
      4'd3:    seg_lut = 7'b0110000;
      4'd4:    seg_lut = 7'b0011001;
      4'd5:    seg_lut = 7'b0010010;
      4'd6:    seg_lut = 7'b0000010;
      4'd7:    seg_lut = 7'b1111000;
      4'd8:    seg_lut = 7'b0000000;
      4'd9:    seg_lut = 7'b0010000;
      default: seg_lut = 7'b1111111;
    endcase
  endfunction

  // Two identical consecutive samples are required before the count is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1  <= '0;
      s2  <= '0;
      cap <= '0;
    end else begin
      s1 <= {bus.minutes, bus.seconds};
      s2 <= s1;
      if (s1 == s2) cap <= s1;
    end
  end

  // Digit scan timebase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_cnt <= '0;
      digit_idx <= '0;
    end else if (digit_cnt == DIV_W'(DIGIT_DIV - 1)) begin
      digit_cnt <= '0;
      digit_idx <= digit_idx + 2'd1;
    end else begin
      digit_cnt <= digit_cnt + DIV_W'(1);
    end
  end

  // Blink phase state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q     <= PH_VISIBLE;
      blink_cnt_q <= '0;
      adjust_q    <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      blink_cnt_q <= blink_cnt_d;
      adjust_q    <= bus.adjust;
    end
  end

  // Entering adjust mode restarts the blink in the lit phase
  always_comb begin
    phase_d     = phase_q;
    blink_cnt_d = blink_cnt_q + BLK_W'(1);
    rise_c      = bus.adjust & ~adjust_q;
    if (rise_c) begin
      blink_cnt_d = '0;
      phase_d     = PH_VISIBLE;
    end else if (blink_cnt_q == BLK_W'(BLINK_HALF - 1)) begin
      blink_cnt_d = '0;
      phase_d     = (phase_q == PH_VISIBLE) ? PH_HIDDEN : PH_VISIBLE;
    end
  end

  // Digit selection, blanking and segment decode for the active index
  always_comb begin
    cap_min = cap[CAP_W-1:VAL_W];
    cap_sec = cap[VAL_W-1:0];
    digit_c = 4'd0;
    case (digit_idx)
      2'd0: digit_c = 4'(cap_sec % 6'd10);
      2'd1: digit_c = 4'(cap_sec / 6'd10);
      2'd2: digit_c = 4'(cap_min % 6'd10);
      2'd3: digit_c = 4'(cap_min / 6'd10);
      default: digit_c = 4'd0;
    endcase
    blank_c = bus.adjust & (phase_q == PH_HIDDEN) & ~rise_c & (digit_idx[1] == bus.select);
`ifdef STOPWATCH_DISPLAY_LZB_EN
    lzb_c = (digit_idx == 2'd3) && (cap_min < 6'd10);
`else
    lzb_c = 1'b0;
`endif
    an_c  = ~(4'b0001 << digit_idx);
    seg_c = (blank_c | lzb_c) ? 7'b1111111 : seg_lut(digit_c);
    dp_c  = ~((digit_idx == 2'd2) & ~blank_c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.an  <= 4'b1111;
      bus.seg <= 7'b1111111;
      bus.dp  <= 1'b1;
    end else begin
      bus.an  <= an_c;
      bus.seg <= seg_c;
      bus.dp  <= dp_c;
    end
  end

endmodule

// File: tb/tb_stopwatch_display.sv
// Bench for stopwatch_display: per-cycle reference model plus directed literal checks.
module tb_stopwatch_display;

  localparam int DIV  = 4;
  localparam int HALF = 200;
`ifdef STOPWATCH_DISPLAY_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  stopwatch_display_if bus();

  stopwatch_display #(.CLK_HZ(800), .REFRESH_HZ(50), .BLINK_HZ(2)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  logic [6:0] seg_tab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  task automatic chk(input string name, input logic [11:0] got, input logic [11:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  int hist [0:4095];
  int e = 0;
  int rise = -1;
  bit prev_adj = 1'b0;

  // Shown value = newest sample equal to its predecessor, at least two edges old
  function automatic int shown_value(input int edge_n);
    for (int j = edge_n - 2; j >= 1 && j > edge_n - 64; j--)
      if (hist[j & 4095] == hist[(j - 1) & 4095]) return hist[j & 4095];
    return 0;
  endfunction

  always @(posedge clk) begin
    int v, mins, secs, idx, dig;
    bit adj, sel, rs, hidden, lz;
    logic [3:0] ean;
    logic [6:0] eseg;
    logic edp;
    v   = {bus.minutes, bus.seconds};
    adj = bus.adjust;
    sel = bus.select;
    rs  = rst_n;
    #1;
    if (!rs) begin
      e = 0; prev_adj = 1'b0; rise = -1; hist[0] = 0;
      chk("reset_outputs", {bus.an, bus.seg, bus.dp}, {4'b1111, 7'b1111111, 1'b1});
    end else begin
      e++;
      hist[e & 4095] = v;
      if (adj && !prev_adj) rise = e;
      prev_adj = adj;
      v    = shown_value(e);
      mins = v / 64;
      secs = v % 64;
      idx  = ((e - 1) / DIV) % 4;
      case (idx)
        0: dig = secs % 10;
        1: dig = secs / 10;
        2: dig = mins % 10;
        default: dig = mins / 10;
      endcase
      hidden = adj && rise > 0 && e > rise && (((e - rise - 1) / HALF) % 2 == 1)
               && ((idx >= 2) == sel);
      lz   = LZB && idx == 3 && mins < 10;
      ean  = 4'b1111 & ~(4'b0001 << idx);
      eseg = (hidden || lz) ? 7'b1111111 : seg_tab[dig];
      edp  = (idx == 2 && !hidden) ? 1'b0 : 1'b1;
      chk("model_cycle", {bus.an, bus.seg, bus.dp}, {ean, eseg, edp});
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_digit(input string name, input int idx, input logic [6:0] eseg, input logic edp);
    logic [3:0] target;
    bit found;
    target = 4'b1111 & ~(4'b0001 << idx);
    found  = 1'b0;
    for (int i = 0; i < 24 && !found; i++) begin
      @(negedge clk);
      if (bus.an == target) found = 1'b1;
    end
    if (!found) chk({name, "_timeout"}, {8'h0, bus.an}, {8'h0, target});
    else chk(name, {4'h0, bus.seg, bus.dp}, {4'h0, eseg, edp});
  endtask

  task automatic set_time(input int m, input int s);
    @(negedge clk);
    bus.minutes = 6'(m);
    bus.seconds = 6'(s);
  endtask

  initial begin
    bus.minutes = '0; bus.seconds = '0; bus.adjust = 1'b0; bus.select = 1'b0;
    #2 rst_n = 1'b0;
    // reset held with inputs toggling
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.minutes = 6'($urandom_range(0, 63));
      bus.seconds = 6'($urandom_range(0, 63));
      bus.adjust  = 1'($urandom_range(0, 1));
      #1 chk("reset_hold", {bus.an, bus.seg, bus.dp}, {4'b1111, 7'b1111111, 1'b1});
    end
    @(negedge clk);
    bus.minutes = 6'd12; bus.seconds = 6'd34; bus.adjust = 1'b0; bus.select = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1 chk("first_anode", {8'h0, bus.an}, {8'h0, 4'b1110});

    // normal display 12.34
    cycles(8);
    expect_digit("n_d0", 0, 7'b0011001, 1'b1);
    expect_digit("n_d1", 1, 7'b0110000, 1'b1);
    expect_digit("n_d2", 2, 7'b0100100, 1'b0);
    expect_digit("n_d3", 3, 7'b1111001, 1'b1);

    // single-cycle glitch on the way 34 -> 35
    set_time(12, 63);
    set_time(12, 35);
    cycles(4);
    expect_digit("glitch_d0", 0, 7'b0010010, 1'b1);
    expect_digit("glitch_d1", 1, 7'b0110000, 1'b1);

    // blink, seconds pair selected
    set_time(5, 9);
    cycles(10);
    @(negedge clk); bus.adjust = 1'b1;
    cycles(20);
    expect_digit("blk_s_lit", 0, 7'b0010000, 1'b1);
    cycles(270);
    expect_digit("blk_s_hid", 0, 7'b1111111, 1'b1);
    expect_digit("blk_s_min", 2, 7'b0010010, 1'b0);
    cycles(100);
    expect_digit("blk_s_relit", 0, 7'b0010000, 1'b1);
    @(negedge clk); bus.adjust = 1'b0;
    cycles(5);
    // blink, minutes pair selected
    @(negedge clk); bus.select = 1'b1; bus.adjust = 1'b1;
    cycles(290);
    expect_digit("blk_m_hid", 2, 7'b1111111, 1'b1);
    expect_digit("blk_m_sec", 0, 7'b0010000, 1'b1);
    @(negedge clk); bus.adjust = 1'b0; bus.select = 1'b0;
    cycles(5);
    expect_digit("blk_off", 2, 7'b0010010, 1'b0);

    // wrap and out-of-range values
    set_time(59, 59);
    cycles(8);
    expect_digit("w59_d0", 0, 7'b0010000, 1'b1);
    expect_digit("w59_d1", 1, 7'b0010010, 1'b1);
    expect_digit("w59_d2", 2, 7'b0010000, 1'b0);
    expect_digit("w59_d3", 3, 7'b0010010, 1'b1);
    set_time(0, 0);
    cycles(8);
    expect_digit("w0_d0", 0, 7'b1000000, 1'b1);
    expect_digit("w0_d2", 2, 7'b1000000, 1'b0);
    expect_digit("w0_d3", 3, LZB ? 7'b1111111 : 7'b1000000, 1'b1);
    set_time(63, 0);
    cycles(8);
    expect_digit("m63_d2", 2, 7'b0110000, 1'b0);
    expect_digit("m63_d3", 3, 7'b0000010, 1'b1);

    // leading zero on minutes tens
    set_time(7, 0);
    cycles(8);
    expect_digit("m7_d3", 3, LZB ? 7'b1111111 : 7'b1000000, 1'b1);
    set_time(10, 0);
    cycles(8);
    expect_digit("m10_d3", 3, 7'b1111001, 1'b1);

    // asynchronous reset in the middle of a scan
    cycles(6);
    @(negedge clk); rst_n = 1'b0;
    #1 chk("async_reset", {bus.an, bus.seg, bus.dp}, {4'b1111, 7'b1111111, 1'b1});
    cycles(2);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1 chk("restart_anode", {8'h0, bus.an}, {8'h0, 4'b1110});
    cycles(20);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
